// File: rtl/pixel_frame_sink.sv
// pixel_frame_sink
//
// Receiving end of the pixel-plot interface. Drawing logic writes single
// pixels (x, y, 3-bit colour) into a 160x120x3-bit frame buffer, and a
// raster timing generator continuously scans that buffer out to the video
// DAC. Sync, blank and colour are registered together, so they line up at
// the pins.
//
// Optional feature: define FB_CLEAR_EN to add a clear sweep after reset.
// The sweep fills the whole buffer with BG_COLOUR before scanning starts.
//
// Ports:
//   clk          clock, all logic on the rising edge
//   resetn       synchronous, active-low reset
//   iX, iY       write column / row
//   iColour      write colour {R,G,B}
//   iPlot        write strobe, one pixel per clk while high
//   oHS, oVS     horizontal / vertical sync, active-low
//   oBlank       high outside the active area
//   oRGB         scanned colour, forced to 0 while blanked
//   oFrameStart  one-clk pulse together with the colour of pixel (0,0)
//   oDropCount   saturating count of out-of-range writes
//   oBusy        high while the clear sweep runs (always 0 without FB_CLEAR_EN)
module pixel_frame_sink #(
    parameter int         X_PIXELS  = 160,
    parameter int         Y_PIXELS  = 120,
    parameter int         H_FP      = 4,
    parameter int         H_SYNC    = 24,
    parameter int         H_BP      = 12,
    parameter int         V_FP      = 1,
    parameter int         V_SYNC    = 2,
    parameter int         V_BP      = 8,
    parameter int         CLK_DIV   = 1,
    parameter logic [2:0] BG_COLOUR = 3'b000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] iX,
    input  logic [6:0] iY,
    input  logic [2:0] iColour,
    input  logic       iPlot,
    output logic       oHS,
    output logic       oVS,
    output logic       oBlank,
    output logic [2:0] oRGB,
    output logic       oFrameStart,
    output logic [7:0] oDropCount,
    output logic       oBusy
);

    localparam int H_TOTAL = X_PIXELS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = Y_PIXELS + V_FP + V_SYNC + V_BP;
    localparam int NUM_PIX = X_PIXELS * Y_PIXELS;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [7:0] X_END    = 8'(X_PIXELS);
    localparam logic [7:0] Y_END    = 8'(Y_PIXELS);
    localparam logic [7:0] H_LAST   = 8'(H_TOTAL - 1);
    localparam logic [7:0] V_LAST   = 8'(V_TOTAL - 1);
    localparam logic [7:0] HS_START = 8'(X_PIXELS + H_FP);
    localparam logic [7:0] HS_END   = 8'(X_PIXELS + H_FP + H_SYNC);
    localparam logic [7:0] VS_START = 8'(Y_PIXELS + V_FP);
    localparam logic [7:0] VS_END   = 8'(Y_PIXELS + V_FP + V_SYNC);
    localparam logic [7:0] X_MULT   = 8'(X_PIXELS);

    // y*X_PIXELS + x built as a sum of shifted copies of y, one per set bit
    // of X_PIXELS (for 160 that is y<<7 + y<<5). Carried out at 15 bits.
    function automatic logic [14:0] pix_addr(input logic [7:0] x, input logic [6:0] y);
        logic [14:0] acc;
        acc = 15'(x);
        for (int i = 0; i < 8; i++) begin
            if (X_MULT[i]) acc = acc + (15'(y) << i);
        end
        return acc;
    endfunction

    logic [2:0]       frame_mem [NUM_PIX];
    logic [DIV_W-1:0] div_cnt;
    logic [7:0]       h;
    logic [7:0]       v;
    logic             tick;
    logic             active;
    logic             hs_next;
    logic             vs_next;
    logic [14:0]      rd_addr;
    logic             in_range;
    logic             plot_ok;
    logic             wr_en;
    logic [14:0]      wr_addr;
    logic [2:0]       wr_data;
    logic             clearing;
    logic [14:0]      clr_addr;

`ifdef FB_CLEAR_EN
    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_SCAN  = 1'b1;
    localparam logic [14:0] LAST_ADDR = 15'(NUM_PIX - 1);

    logic [0:0] state;

    // Clear sweep: one address per clk from 0 to the last pixel, then hand
    // over to scanning. Any reset restarts the sweep from address 0.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= ST_CLEAR;
            clr_addr <= '0;
        end else if (state == ST_CLEAR) begin
            if (clr_addr == LAST_ADDR) begin
                state <= ST_SCAN;
            end else begin
                clr_addr <= clr_addr + 15'd1;
            end
        end
    end

    assign clearing = (state == ST_CLEAR);
`else
    assign clearing = 1'b0;
    assign clr_addr = '0;
`endif

    assign oBusy = clearing;

    assign tick     = (div_cnt == DIV_LAST);
    assign active   = (h < X_END) && (v < Y_END);
    assign hs_next  = !((h >= HS_START) && (h < HS_END));
    assign vs_next  = !((v >= VS_START) && (v < VS_END));
    assign rd_addr  = active ? pix_addr(h, v[6:0]) : 15'd0;

    assign in_range = (iX < X_END) && ({1'b0, iY} < Y_END);
    assign plot_ok  = iPlot && in_range && !clearing;
    assign wr_en    = resetn && (clearing || plot_ok);
    assign wr_addr  = clearing ? clr_addr : pix_addr(iX, iY);
    assign wr_data  = clearing ? BG_COLOUR : iColour;

    // Frame buffer write port. Left without reset so the picture survives
    // a reset; the scan below samples the entry before this edge updates it.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            frame_mem[wr_addr] <= wr_data;
        end
    end

    // Raster counters and the output register stage. On each pixel tick
    // the colour of (h,v) and the sync/blank decoded from the same (h,v)
    // are captured together, so all outputs describe one pixel. The raster
    // is parked at (0,0) with outputs at reset values while clearing.
    always_ff @(posedge clk) begin
        if (!resetn || clearing) begin
            div_cnt     <= '0;
            h           <= '0;
            v           <= '0;
            oHS         <= 1'b1;
            oVS         <= 1'b1;
            oBlank      <= 1'b1;
            oRGB        <= 3'b000;
            oFrameStart <= 1'b0;
        end else begin
            oFrameStart <= 1'b0;
            if (tick) begin
                div_cnt     <= '0;
                oHS         <= hs_next;
                oVS         <= vs_next;
                oBlank      <= !active;
                oRGB        <= active ? frame_mem[rd_addr] : 3'b000;
                oFrameStart <= (h == 8'd0) && (v == 8'd0);
                if (h == H_LAST) begin
                    h <= '0;
                    v <= (v == V_LAST) ? 8'd0 : v + 8'd1;
                end else begin
                    h <= h + 8'd1;
                end
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

    // Rejected-write counter, saturating at 255. Writes swallowed by the
    // clear sweep are not rejections and are not counted.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            oDropCount <= 8'd0;
        end else if (iPlot && !clearing && !in_range && (oDropCount != 8'hFF)) begin
            oDropCount <= oDropCount + 8'd1;
        end
    end

endmodule

// File: tb/tb_pixel_frame_sink.sv
// tb_pixel_frame_sink
//
// Directed bench for pixel_frame_sink in its default build. A cycle counter
// that restarts with reset gives the raster position of the pixel currently
// on the outputs: after the k-th clk following reset release the outputs
// show pixel k-1 in raster order (200 ticks per line, 131 lines per frame).
// Expected colours come from the pixels the bench itself wrote.
module tb_pixel_frame_sink;

    logic       clk = 1'b0;
    logic       resetn;
    logic [7:0] iX;
    logic [6:0] iY;
    logic [2:0] iColour;
    logic       iPlot;
    logic       oHS;
    logic       oVS;
    logic       oBlank;
    logic [2:0] oRGB;
    logic       oFrameStart;
    logic [7:0] oDropCount;
    logic       oBusy;

    int check_count = 0;
    int fail_count  = 0;
    int cyc         = 0;
    int fs_count    = 0;

    pixel_frame_sink dut (
        .clk         (clk),
        .resetn      (resetn),
        .iX          (iX),
        .iY          (iY),
        .iColour     (iColour),
        .iPlot       (iPlot),
        .oHS         (oHS),
        .oVS         (oVS),
        .oBlank      (oBlank),
        .oRGB        (oRGB),
        .oFrameStart (oFrameStart),
        .oDropCount  (oDropCount),
        .oBusy       (oBusy)
    );

    always #5 clk = ~clk;

    // Clk edges since reset release; the output pixel index is cyc-1.
    always @(posedge clk) begin
        if (!resetn) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    // Count every frame-start pulse, sampled just after the edge.
    always @(posedge clk) begin
        #1;
        if (oFrameStart === 1'b1) fs_count++;
    end

    function automatic int out_h();
        return (cyc - 1) % 200;
    endfunction

    function automatic int out_v();
        return ((cyc - 1) / 200) % 131;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Hold the given write inputs across exactly one rising edge.
    task automatic applyStimulus(input int x, input int y, input int c, input logic plot);
        iX      = 8'(x);
        iY      = 7'(y);
        iColour = 3'(c);
        iPlot   = plot;
        @(negedge clk);
    endtask

    // Advance to the negedge where pixel (h,v) is on the outputs.
    task automatic waitFor(input int h, input int v, input string tag);
        int n;
        n = 0;
        while (!(cyc >= 1 && out_h() == h && out_v() == v)) begin
            if (n >= 30000) begin
                checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
                return;
            end
            @(negedge clk);
            n++;
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_hs"},    32'(oHS),         32'd1);
        checkOutput({tag, "_vs"},    32'(oVS),         32'd1);
        checkOutput({tag, "_blank"}, 32'(oBlank),      32'd1);
        checkOutput({tag, "_rgb"},   32'(oRGB),        32'd0);
        checkOutput({tag, "_fs"},    32'(oFrameStart), 32'd0);
        checkOutput({tag, "_drop"},  32'(oDropCount),  32'd0);
        checkOutput({tag, "_busy"},  32'(oBusy),       32'd0);
    endtask

    initial begin
        resetn  = 1'b0;
        iX      = '0;
        iY      = '0;
        iColour = '0;
        iPlot   = 1'b0;
        repeat (3) @(negedge clk);
        checkResetValues("rst");

        // Release; the first edge presents pixel (0,0) with the frame pulse.
        resetn = 1'b1;
        @(negedge clk);
        checkOutput("first_fs",    32'(oFrameStart), 32'd1);
        checkOutput("first_blank", 32'(oBlank),      32'd0);

        applyStimulus(0, 0, 7, 1'b1);
        checkOutput("fs_one_clk", 32'(oFrameStart), 32'd0);
        applyStimulus(5, 3, 5, 1'b1);
        applyStimulus(4, 3, 2, 1'b1);
        applyStimulus(6, 3, 3, 1'b1);
        applyStimulus(5, 2, 6, 1'b1);
        applyStimulus(10, 10, 1, 1'b1);
        applyStimulus(160, 0, 4, 1'b1);
        applyStimulus(0, 120, 4, 1'b1);
        applyStimulus(5, 3, 0, 1'b0);
        applyStimulus(0, 0, 0, 1'b0);
        checkOutput("drop_two", 32'(oDropCount), 32'd2);

        // Target pixel and its neighbours in the current frame.
        waitFor(5, 2, "w52");
        checkOutput("pix_5_2", 32'(oRGB), 32'd6);
        waitFor(4, 3, "w43");
        checkOutput("pix_4_3", 32'(oRGB), 32'd2);
        @(negedge clk);
        checkOutput("pix_5_3", 32'(oRGB), 32'd5);
        checkOutput("pix_5_3_blank", 32'(oBlank), 32'd0);
        @(negedge clk);
        checkOutput("pix_6_3", 32'(oRGB), 32'd3);

        // Horizontal blanking and sync edges on line 3.
        waitFor(160, 3, "w160");
        checkOutput("hblank", 32'(oBlank), 32'd1);
        checkOutput("hblank_rgb", 32'(oRGB), 32'd0);
        waitFor(163, 3, "w163");
        checkOutput("hs_163", 32'(oHS), 32'd1);
        @(negedge clk);
        checkOutput("hs_164", 32'(oHS), 32'd0);
        waitFor(187, 3, "w187");
        checkOutput("hs_187", 32'(oHS), 32'd0);
        @(negedge clk);
        checkOutput("hs_188", 32'(oHS), 32'd1);

        // Write (10,10) on the very edge that scans it: old colour now.
        waitFor(9, 10, "w9_10");
        applyStimulus(10, 10, 6, 1'b1);
        checkOutput("rbw_old", 32'(oRGB), 32'd1);
        applyStimulus(0, 0, 0, 1'b0);

        // Vertical sync lines.
        waitFor(0, 120, "w0_120");
        checkOutput("vs_120", 32'(oVS), 32'd1);
        waitFor(0, 121, "w0_121");
        checkOutput("vs_121", 32'(oVS), 32'd0);
        checkOutput("vblank_121", 32'(oBlank), 32'd1);
        waitFor(199, 122, "w199_122");
        checkOutput("vs_122", 32'(oVS), 32'd0);
        @(negedge clk);
        checkOutput("vs_123", 32'(oVS), 32'd1);

        // Second frame: exactly one pulse per frame so far, new colours visible.
        waitFor(0, 0, "w0_0");
        checkOutput("fs_frame1", 32'(oFrameStart), 32'd1);
        checkOutput("fs_count", 32'(fs_count), 32'd2);
        checkOutput("pix_0_0", 32'(oRGB), 32'd7);
        waitFor(5, 3, "w53_f1");
        checkOutput("pix_5_3_f1", 32'(oRGB), 32'd5);
        waitFor(10, 10, "w10_10");
        checkOutput("rbw_new", 32'(oRGB), 32'd6);

        // Mid-frame reset at line 60.
        waitFor(80, 60, "w80_60");
        checkOutput("drop_before_rst", 32'(oDropCount), 32'd2);
        resetn = 1'b0;
        @(negedge clk);
        checkResetValues("midrst");
        resetn = 1'b1;
        @(negedge clk);
        checkOutput("restart_fs", 32'(oFrameStart), 32'd1);
        checkOutput("restart_pix_0_0", 32'(oRGB), 32'd7);
        waitFor(5, 3, "w53_rst");
        checkOutput("retained_5_3", 32'(oRGB), 32'd5);

        // Drop counter saturation.
        for (int i = 0; i < 300; i++) begin
            applyStimulus(200, 0, 1, 1'b1);
        end
        applyStimulus(0, 0, 0, 1'b0);
        checkOutput("drop_sat", 32'(oDropCount), 32'd255);

        $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
        $finish;
    end

endmodule
